// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RV32 pipeline: shadow E/M/W control
// pipe, load-use/branch stall and flush, operand forwarding, and the data-memory wait FSM.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] RdD,
   input  logic       RegWriteD,
   input  logic [1:0] ResultSrcD,
   input  logic       MemWriteD,
   input  logic       PCSrcE,
   input  logic       dmem_ready,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       dmem_req,
   output logic       mem_err
);

   // Each stage only carries the fields something downstream of it still reads.
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } e_ctrl_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } m_ctrl_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
   } w_ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   e_ctrl_t          e_q, e_d;
   m_ctrl_t          m_q, m_d;
   w_ctrl_t          w_q, w_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic memop_m;
   logic freeze;
   logic lw_stall;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       reg_write_m,
      input logic [4:0] rd_m,
      input logic       reg_write_w,
      input logic [4:0] rd_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign memop_m = (m_q.result_src == 2'b01) || m_q.mem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q        <= '0;
         m_q        <= '0;
         w_q        <= '0;
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         e_q        <= e_d;
         m_q        <= m_d;
         w_q        <= w_d;
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // The counter holds the number of not-ready cycles already spent on the current access.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (memop_m && !dmem_ready) begin
               state_d    = ST_WAIT;
               wait_cnt_d = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (dmem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      freeze   = 1'b0;
      dmem_req = 1'b0;
      mem_err  = 1'b0;
      case (state_q)
         ST_RUN: begin
            dmem_req = memop_m;
            freeze   = memop_m && !dmem_ready;
         end
         ST_WAIT: begin
            dmem_req = 1'b1;
            freeze   = !dmem_ready;
         end
         ST_ERR: begin
            mem_err = 1'b1;
            freeze  = 1'b1;
         end
         default: begin
            freeze = 1'b0;
         end
      endcase
   end

   assign lw_stall = (e_q.result_src == 2'b01) && (e_q.rd != 5'd0) &&
                     ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

   // A frozen pipe ignores branches and load-use; a taken branch overrides the load-use hold.
   always_comb begin
      StallF = freeze || (lw_stall && !PCSrcE);
      StallD = freeze || (lw_stall && !PCSrcE);
      StallE = freeze;
      StallM = freeze;
      FlushD = !freeze && PCSrcE;
      FlushE = !freeze && (PCSrcE || lw_stall);
      FlushW = freeze;
   end

   always_comb begin
      ForwardAE = fwd_sel(e_q.rs1, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
      ForwardBE = fwd_sel(e_q.rs2, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
   end

   always_comb begin
      e_d = e_q;
      if (FlushE) begin
         e_d = '0;
      end else if (!StallE) begin
         e_d.rs1        = Rs1D;
         e_d.rs2        = Rs2D;
         e_d.rd         = RdD;
         e_d.reg_write  = RegWriteD;
         e_d.result_src = ResultSrcD;
         e_d.mem_write  = MemWriteD;
      end

      m_d = m_q;
      if (!StallM) begin
         m_d.rd         = e_q.rd;
         m_d.reg_write  = e_q.reg_write;
         m_d.result_src = e_q.result_src;
         m_d.mem_write  = e_q.mem_write;
      end

      if (FlushW) begin
         w_d = '0;
      end else begin
         w_d.rd        = m_q.rd;
         w_d.reg_write = m_q.reg_write;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, memory-wait and
// watchdog sequences, then randomized traffic against an instruction-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 5;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] rsrc;
      logic       mw;
   } instr_t;

   typedef struct {
      instr_t      d;
      logic        pc;
      logic        rdy;
      logic [12:0] exp;
      string       name;
   } vec_t;

   logic       clk;
   logic       rst_n;
   instr_t     d_in;
   logic       PCSrcE;
   logic       dmem_ready;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       dmem_req, mem_err;
   logic [12:0] act_vec;

   int checks = 0;
   int errors = 0;

   instr_t mdl_e, mdl_m, mdl_w;
   int     mdl_waits;
   bit     mdl_err;

   vec_t tbl[13];

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Rs1D      (d_in.rs1),
      .Rs2D      (d_in.rs2),
      .RdD       (d_in.rd),
      .RegWriteD (d_in.rw),
      .ResultSrcD(d_in.rsrc),
      .MemWriteD (d_in.mw),
      .PCSrcE    (PCSrcE),
      .dmem_ready(dmem_ready),
      .StallF    (StallF),
      .StallD    (StallD),
      .StallE    (StallE),
      .StallM    (StallM),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .FlushW    (FlushW),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .dmem_req  (dmem_req),
      .mem_err   (mem_err)
   );

   assign act_vec = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAE, ForwardBE, dmem_req, mem_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                 input bit rw, input int rsrc, input bit mw);
      instr_t t;
      t.rs1  = 5'(rs1);
      t.rs2  = 5'(rs2);
      t.rd   = 5'(rd);
      t.rw   = rw;
      t.rsrc = 2'(rsrc);
      t.mw   = mw;
      return t;
   endfunction

   function automatic logic [12:0] ov(input bit stf, input bit std, input bit ste, input bit stm,
                                      input bit fd, input bit fe, input bit fw,
                                      input bit [1:0] fa, input bit [1:0] fb,
                                      input bit req, input bit err);
      return {stf, std, ste, stm, fd, fe, fw, fa, fb, req, err};
   endfunction

   // Reference model: a memory op in M is outstanding until a ready cycle; the watchdog
   // trips once MEM_TIMEOUT consecutive unready cycles have been spent on it.
   function automatic bit [1:0] mdlFwd(input logic [4:0] src);
      if (mdl_m.rw && mdl_m.rd != 0 && mdl_m.rd == src) return 2'b10;
      if (mdl_w.rw && mdl_w.rd != 0 && mdl_w.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit mdlPending();
      return !mdl_err && (mdl_waits > 0 || mdl_m.rsrc == 2'b01 || mdl_m.mw);
   endfunction

   function automatic bit mdlLoadUse(input instr_t d);
      return mdl_e.rsrc == 2'b01 && mdl_e.rd != 0 && (mdl_e.rd == d.rs1 || mdl_e.rd == d.rs2);
   endfunction

   function automatic logic [12:0] modelExpect(input instr_t d, input logic pc, input logic rdy);
      bit frozen, lu;
      frozen = mdl_err || (mdlPending() && !rdy);
      lu     = mdlLoadUse(d);
      return ov(frozen || (lu && !pc), frozen || (lu && !pc), frozen, frozen,
                !frozen && pc, !frozen && (pc || lu), frozen,
                mdlFwd(mdl_e.rs1), mdlFwd(mdl_e.rs2), mdlPending(), mdl_err);
   endfunction

   task automatic modelStep(input instr_t d, input logic pc, input logic rdy);
      bit frozen, flush_e;
      frozen  = mdl_err || (mdlPending() && !rdy);
      flush_e = !frozen && (pc || mdlLoadUse(d));
      if (!mdl_err) begin
         if (mdlPending() && !rdy) begin
            mdl_waits++;
            if (mdl_waits == MEM_TIMEOUT) mdl_err = 1'b1;
         end else begin
            mdl_waits = 0;
         end
      end
      if (frozen) begin
         mdl_w = '0;
      end else begin
         mdl_w = mdl_m;
         mdl_m = mdl_e;
         mdl_e = flush_e ? instr_t'(0) : d;
      end
   endtask

   task automatic modelReset();
      mdl_e     = '0;
      mdl_m     = '0;
      mdl_w     = '0;
      mdl_waits = 0;
      mdl_err   = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [12:0] exp);
      checks++;
      if (act_vec !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b required %b (StallFDEM FlushDEW FwdA FwdB req err)",
                  name, act_vec, exp);
      end
   endtask

   task automatic applyStimulus(input instr_t d, input logic pc, input logic rdy);
      @(negedge clk);
      d_in       = d;
      PCSrcE     = pc;
      dmem_ready = rdy;
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n      = 1'b0;
      d_in       = '0;
      PCSrcE     = 1'b0;
      dmem_ready = 1'b1;
      #1;
      checkOutput("reset_state", 13'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [12:0] frozen_v, err_v, req_v, zero_v;
      instr_t      nop, sw_i, lw_i, d;
      logic        pc, rdy;
      int          hold_low;

      frozen_v = ov(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0);
      err_v    = ov(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1);
      req_v    = ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
      zero_v   = 13'd0;
      nop      = '0;
      sw_i     = mk(1, 2, 0, 0, 0, 1);
      lw_i     = mk(1, 0, 3, 1, 1, 0);

      tbl[0]  = '{mk(1, 2, 5, 1, 0, 0),    0, 1, zero_v, "add_x5"};
      tbl[1]  = '{mk(5, 5, 6, 1, 0, 0),    0, 1, zero_v, "add_x6_dec"};
      tbl[2]  = '{mk(5, 3, 7, 1, 0, 0),    0, 1, ov(0,0,0,0,0,0,0,2'b10,2'b10,0,0), "fwd_from_M"};
      tbl[3]  = '{mk(1, 0, 10, 1, 1, 0),   0, 1, ov(0,0,0,0,0,0,0,2'b01,2'b00,0,0), "fwd_from_W"};
      tbl[4]  = '{mk(10, 1, 11, 1, 0, 0),  0, 1, ov(1,1,0,0,0,1,0,2'b00,2'b00,0,0), "load_use"};
      tbl[5]  = '{mk(10, 1, 11, 1, 0, 0),  0, 1, req_v, "load_in_M"};
      tbl[6]  = '{nop,                     0, 1, ov(0,0,0,0,0,0,0,2'b01,2'b00,0,0), "load_fwd_W"};
      tbl[7]  = '{mk(0, 0, 0, 1, 0, 0),    0, 1, zero_v, "x0_dec"};
      tbl[8]  = '{nop,                     0, 1, zero_v, "x0_in_E"};
      tbl[9]  = '{mk(2, 0, 12, 1, 1, 0),   0, 1, zero_v, "x0_in_M_no_fwd"};
      tbl[10] = '{mk(12, 12, 13, 1, 0, 0), 1, 1, ov(0,0,0,0,1,1,0,2'b00,2'b00,0,0), "branch_over_lu"};
      tbl[11] = '{nop,                     0, 1, req_v, "branch_load_M"};
      tbl[12] = '{nop,                     0, 1, zero_v, "drain"};

      rst_n      = 1'b1;
      d_in       = '0;
      PCSrcE     = 1'b0;
      dmem_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", zero_v);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i].d, tbl[i].pc, tbl[i].rdy);
         checkOutput(tbl[i].name, tbl[i].exp);
      end

      // Store held off by memory for three cycles, branch arriving while frozen.
      doReset();
      applyStimulus(sw_i, 0, 1);
      checkOutput("sw_dec", zero_v);
      applyStimulus(nop, 0, 1);
      checkOutput("sw_in_E", zero_v);
      applyStimulus(nop, 0, 0);
      checkOutput("sw_wait1", frozen_v);
      applyStimulus(nop, 1, 0);
      checkOutput("sw_wait2_branch", frozen_v);
      applyStimulus(nop, 0, 0);
      checkOutput("sw_wait3", frozen_v);
      applyStimulus(nop, 1, 1);
      checkOutput("sw_release", ov(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0));
      applyStimulus(nop, 0, 1);
      checkOutput("sw_after", zero_v);

      // Load that never completes trips the watchdog.
      doReset();
      applyStimulus(lw_i, 0, 1);
      checkOutput("lw_dec", zero_v);
      applyStimulus(nop, 0, 1);
      checkOutput("lw_in_E", zero_v);
      for (int k = 1; k <= MEM_TIMEOUT; k++) begin
         applyStimulus(nop, 0, 0);
         checkOutput($sformatf("lw_wait%0d", k), frozen_v);
      end
      applyStimulus(nop, 0, 0);
      checkOutput("watchdog_err", err_v);
      applyStimulus(nop, 1, 1);
      checkOutput("err_sticky", err_v);
      doReset();
      applyStimulus(nop, 0, 1);
      checkOutput("err_cleared", zero_v);

      // Reset in the middle of a wait abandons the access.
      applyStimulus(lw_i, 0, 1);
      applyStimulus(nop, 0, 1);
      applyStimulus(nop, 0, 0);
      checkOutput("midwait_frozen", frozen_v);
      doReset();
      applyStimulus(nop, 0, 1);
      checkOutput("midwait_aborted", zero_v);

      doReset();
      modelReset();
      hold_low = 0;
      for (int n = 0; n < 3000; n++) begin
         if (mdl_err) begin
            doReset();
            modelReset();
         end
         d = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         pc = ($urandom_range(0, 7) == 0);
         if (hold_low > 0) begin
            rdy = 1'b0;
            hold_low--;
         end else begin
            if ($urandom_range(0, 99) < 3) hold_low = $urandom_range(1, 20);
            rdy = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(d, pc, rdy);
         checkOutput("random", modelExpect(d, pc, rdy));
         @(posedge clk);
         modelStep(d, pc, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
